// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_rr_arbiter
// Purpose  : Round-robin scheduler that shares NUM_SLOTS common-data-bus
//            broadcast slots among NUM_REQ functional-unit writeback
//            requesters. Up to NUM_SLOTS requesters are granted per cycle,
//            packed contiguously into slots 0..k-1 in scan order starting at
//            rr_ptr, with early tags emitted the same cycle. The granted
//            tag/data are registered into the CDB output stage and broadcast
//            the following cycle.
// Ports    : clock, reset (sync, active-low)
//            req/req_tag/req_data  - per-FU writeback request, tag, result
//            hold                  - CDB stall, suppresses all grants
//            gnt                   - combinational per-FU grant
//            early_valid/early_tag - same-cycle per-slot tag
//            cdb_valid/tag/data    - registered per-slot broadcast
//            rr_ptr                - current highest-priority index
//            stat_grants/stat_full - saturating counters (CDB_ARB_STATS_EN)
// Options  : define CDB_ARB_STATS_EN to add the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_rr_arbiter #(
    parameter int NUM_REQ   = 8,
    parameter int NUM_SLOTS = 3,
    parameter int TAG_W     = 6,
    parameter int DATA_W    = 32
) (
    input  logic                                        clock,
    input  logic                                        reset,
    input  logic [NUM_REQ-1:0]                          req,
    input  logic [NUM_REQ*TAG_W-1:0]                    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]                   req_data,
    input  logic                                        hold,
    output logic [NUM_REQ-1:0]                          gnt,
    output logic [NUM_SLOTS-1:0]                        early_valid,
    output logic [NUM_SLOTS*TAG_W-1:0]                  early_tag,
    output logic [NUM_SLOTS-1:0]                        cdb_valid,
    output logic [NUM_SLOTS*TAG_W-1:0]                  cdb_tag,
    output logic [NUM_SLOTS*DATA_W-1:0]                 cdb_data,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rr_ptr
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [31:0]                                 stat_grants,
    output logic [31:0]                                 stat_full
`endif
);

    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_cnt_w = $clog2(NUM_SLOTS + 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_ptr_w-1:0]          rr_ptr_q,    rr_ptr_d;
    logic [NUM_SLOTS-1:0]        cdb_valid_q, cdb_valid_d;
    logic [NUM_SLOTS*TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [NUM_SLOTS*DATA_W-1:0] cdb_data_q,  cdb_data_d;

    // ------------------------------------------------------------------
    // Grant selection
    // ------------------------------------------------------------------
    logic                        w_active;
    logic [c_ptr_w:0]            w_scan;
    logic [c_ptr_w-1:0]          w_idx;
    logic [c_ptr_w-1:0]          w_last;
    logic [c_ptr_w:0]            w_last_inc;
    logic [c_cnt_w-1:0]          w_cnt;
    logic [NUM_REQ-1:0]          w_gnt;
    logic [NUM_SLOTS-1:0]        w_early_valid;
    logic [NUM_SLOTS*TAG_W-1:0]  w_early_tag;
    logic [NUM_SLOTS*DATA_W-1:0] w_slot_data;

    // Reset and hold both squash every grant combinationally.
    assign w_active = reset & ~hold;

    always_comb begin
        w_scan        = '0;
        w_idx         = '0;
        w_last        = '0;
        w_cnt         = '0;
        w_gnt         = '0;
        w_early_valid = '0;
        w_early_tag   = '0;
        w_slot_data   = '0;
        // Walk the requesters in priority order rr_ptr, rr_ptr+1, ...
        // The running grant count is the slot the next grantee lands in,
        // which keeps the occupied slots contiguous from slot 0.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, rr_ptr_q} + (c_ptr_w + 1)'(k);
            if (w_scan >= (c_ptr_w + 1)'(NUM_REQ)) begin
                w_scan = w_scan - (c_ptr_w + 1)'(NUM_REQ);
            end
            w_idx = w_scan[c_ptr_w-1:0];
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((c_ptr_w'(i) == w_idx) && w_active && req[i]
                    && (w_cnt < c_cnt_w'(NUM_SLOTS))) begin
                    w_gnt[i] = 1'b1;
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        if (w_cnt == c_cnt_w'(s)) begin
                            w_early_valid[s]                  = 1'b1;
                            w_early_tag[s*TAG_W +: TAG_W]     = req_tag[i*TAG_W +: TAG_W];
                            w_slot_data[s*DATA_W +: DATA_W]   = req_data[i*DATA_W +: DATA_W];
                        end
                    end
                    w_last = c_ptr_w'(i);
                    w_cnt  = w_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state: pointer moves just past the last grantee, else stays.
    // ------------------------------------------------------------------
    always_comb begin
        w_last_inc = {1'b0, w_last} + (c_ptr_w + 1)'(1);
        if (w_last_inc >= (c_ptr_w + 1)'(NUM_REQ)) begin
            w_last_inc = '0;
        end
        rr_ptr_d    = (w_cnt != '0) ? w_last_inc[c_ptr_w-1:0] : rr_ptr_q;
        cdb_valid_d = w_early_valid;
        cdb_tag_d   = w_early_tag;
        cdb_data_d  = w_slot_data;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign gnt         = w_gnt;
    assign early_valid = w_early_valid;
    assign early_tag   = w_early_tag;
    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_data    = cdb_data_q;
    assign rr_ptr      = rr_ptr_q;

`ifdef CDB_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    logic [31:0] stat_grants_q, stat_grants_d;
    logic [31:0] stat_full_q,   stat_full_d;
    logic [32:0] w_grants_sum;
    logic        w_full;

    // A cycle is "full" when demand exceeds the broadcast width.
    assign w_full = ($countones(req) > NUM_SLOTS) && !hold;

    always_comb begin
        w_grants_sum  = {1'b0, stat_grants_q} + 33'(w_cnt);
        stat_grants_d = w_grants_sum[32] ? '1 : w_grants_sum[31:0];
        stat_full_d   = stat_full_q;
        if (w_full && (stat_full_q != '1)) begin
            stat_full_d = stat_full_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_grants_q <= '0;
            stat_full_q   <= '0;
        end else begin
            stat_grants_q <= stat_grants_d;
            stat_full_q   <= stat_full_d;
        end
    end

    assign stat_grants = stat_grants_q;
    assign stat_full   = stat_full_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_rr_arbiter
// Purpose  : Self-checking bench for cdb_rr_arbiter. Directed steps from the
//            test plan followed by a short random phase; expected broadcast
//            results are queued when stimulus is applied and popped when the
//            registered CDB stage produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_rr_arbiter;

    localparam int NR = 8;
    localparam int NS = 3;
    localparam int TW = 6;
    localparam int DW = 32;

    logic             clock = 1'b0;
    logic             reset;
    logic [NR-1:0]    req;
    logic [NR*TW-1:0] req_tag;
    logic [NR*DW-1:0] req_data;
    logic             hold;
    logic [NR-1:0]    gnt;
    logic [NS-1:0]    early_valid;
    logic [NS*TW-1:0] early_tag;
    logic [NS-1:0]    cdb_valid;
    logic [NS*TW-1:0] cdb_tag;
    logic [NS*DW-1:0] cdb_data;
    logic [2:0]       rr_ptr;
`ifdef CDB_ARB_STATS_EN
    logic [31:0]      stat_grants;
    logic [31:0]      stat_full;
    longint           m_sg;
    longint           m_sf;
`endif

    always #5 clock = ~clock;

    cdb_rr_arbiter #(
        .NUM_REQ   (NR),
        .NUM_SLOTS (NS),
        .TAG_W     (TW),
        .DATA_W    (DW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .req_tag     (req_tag),
        .req_data    (req_data),
        .hold        (hold),
        .gnt         (gnt),
        .early_valid (early_valid),
        .early_tag   (early_tag),
        .cdb_valid   (cdb_valid),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .rr_ptr      (rr_ptr)
`ifdef CDB_ARB_STATS_EN
        ,
        .stat_grants (stat_grants),
        .stat_full   (stat_full)
`endif
    );

    typedef struct packed {
        logic [NS-1:0]    v;
        logic [NS*TW-1:0] t;
        logic [NS*DW-1:0] d;
        logic [2:0]       p;
    } exp_t;

    exp_t             sb[$];
    int               tests = 0;
    int               fails = 0;
    int               m_ptr = 0;
    logic [NR-1:0]    last_gnt;
    logic [NS-1:0]    last_ev;
    logic [NS*TW-1:0] last_etag;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        assert (act === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge: applies inputs, checks same-cycle outputs,
    // queues the expected broadcast, then checks it at the next negedge.
    task automatic step(input logic [NR-1:0] r, input logic h, input logic rn);
        logic [NR-1:0]    eg;
        logic [NS-1:0]    ev;
        logic [NS*TW-1:0] et;
        logic [NS*DW-1:0] ed;
        int               n;
        int               idx;
        int               last;
        int               nptr;
        exp_t             e;
        req   = r;
        hold  = h;
        reset = rn;
        eg = '0; ev = '0; et = '0; ed = '0; n = 0; last = 0;
        for (int j = 0; j < NR; j++) begin
            idx = (m_ptr + j) % NR;
            if (rn && !h && r[idx] && n < NS) begin
                eg[idx]        = 1'b1;
                ev[n]          = 1'b1;
                et[n*TW +: TW] = req_tag[idx*TW +: TW];
                ed[n*DW +: DW] = req_data[idx*DW +: DW];
                last = idx;
                n++;
            end
        end
        if (!rn)        nptr = 0;
        else if (n > 0) nptr = (last + 1) % NR;
        else            nptr = m_ptr;
`ifdef CDB_ARB_STATS_EN
        if (!rn) begin
            m_sg = 0;
            m_sf = 0;
        end else begin
            m_sg = m_sg + n;
            if ($countones(r) > NS && !h) m_sf = m_sf + 1;
        end
`endif
        e.v = rn ? ev : '0;
        e.t = rn ? et : '0;
        e.d = rn ? ed : '0;
        e.p = 3'(nptr);
        sb.push_back(e);
        #2;
        chk("gnt", gnt, eg);
        chk("early_valid", early_valid, ev);
        chk("early_tag", early_tag, et);
        last_gnt  = gnt;
        last_ev   = early_valid;
        last_etag = early_tag;
        @(negedge clock);
        e = sb.pop_front();
        chk("cdb_valid", cdb_valid, e.v);
        chk("cdb_tag", cdb_tag, e.t);
        chk("cdb_data", cdb_data, e.d);
        chk("rr_ptr", rr_ptr, e.p);
`ifdef CDB_ARB_STATS_EN
        chk("stat_grants", stat_grants, m_sg[31:0]);
        chk("stat_full", stat_full, m_sf[31:0]);
`endif
        m_ptr = nptr;
    endtask

    initial begin
        reset    = 1'b0;
        hold     = 1'b0;
        req      = '0;
        req_tag  = '0;
        req_data = '0;
`ifdef CDB_ARB_STATS_EN
        m_sg = 0;
        m_sf = 0;
`endif
        for (int i = 0; i < NR; i++) begin
            req_tag[i*TW +: TW]  = 6'(i + 8);
            req_data[i*DW +: DW] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end
        req_data[2*DW +: DW] = 32'hDEAD_BEEF;
        @(negedge clock);

        // Reset with all requesting
        step(8'hFF, 1'b0, 1'b0);
        chk("rst_gnt", last_gnt, 8'h00);
        chk("rst_ev", last_ev, 3'b000);
        step(8'hFF, 1'b0, 1'b0);
        chk("rst_cdb_valid", cdb_valid, 3'b000);
        chk("rst_ptr", rr_ptr, 3'd0);

        // Single request
        step(8'b0000_0100, 1'b0, 1'b1);
        chk("single_gnt", last_gnt, 8'b0000_0100);
        chk("single_ev", last_ev, 3'b001);
        chk("single_etag0", last_etag[TW-1:0], 6'd10);
        chk("single_cdb_valid", cdb_valid, 3'b001);
        chk("single_cdb_tag0", cdb_tag[TW-1:0], 6'd10);
        chk("single_cdb_data0", cdb_data[DW-1:0], 32'hDEAD_BEEF);
        chk("single_ptr", rr_ptr, 3'd3);

        // Wrap the pointer back to 0
        step(8'h80, 1'b0, 1'b1);
        chk("wrap_ptr", rr_ptr, 3'd0);

        // Full contention
        step(8'hFF, 1'b0, 1'b1);
        chk("full1_gnt", last_gnt, 8'h07);
        chk("full1_ptr", rr_ptr, 3'd3);
        chk("full1_valid", cdb_valid, 3'b111);
        step(8'hFF, 1'b0, 1'b1);
        chk("full2_gnt", last_gnt, 8'h38);
        chk("full2_ptr", rr_ptr, 3'd6);
        chk("full2_valid", cdb_valid, 3'b111);
        step(8'hFF, 1'b0, 1'b1);
        chk("full3_gnt", last_gnt, 8'hC1);
        chk("full3_ptr", rr_ptr, 3'd1);
        chk("full3_valid", cdb_valid, 3'b111);

        // Move pointer to 5, then slot packing
        step(8'h10, 1'b0, 1'b1);
        chk("pre_pack_ptr", rr_ptr, 3'd5);
        step(8'b1001_0000, 1'b0, 1'b1);
        chk("pack_gnt", last_gnt, 8'b1001_0000);
        chk("pack_ev", last_ev, 3'b011);
        chk("pack_etag", last_etag, {6'd0, 6'd12, 6'd15});
        chk("pack_ptr", rr_ptr, 3'd5);

        // Hold
        step(8'h0F, 1'b1, 1'b1);
        chk("hold_gnt", last_gnt, 8'h00);
        chk("hold_valid", cdb_valid, 3'b000);
        chk("hold_ptr", rr_ptr, 3'd5);
        step(8'h0F, 1'b0, 1'b1);
        chk("unhold_gnt", last_gnt, 8'h07);
        chk("unhold_ptr", rr_ptr, 3'd3);

        // Reset mid-broadcast
        step(8'h01, 1'b0, 1'b1);
        chk("inflight_valid", cdb_valid, 3'b001);
        step(8'h01, 1'b0, 1'b0);
        chk("midrst_valid", cdb_valid, 3'b000);
        chk("midrst_ptr", rr_ptr, 3'd0);
`ifdef CDB_ARB_STATS_EN
        chk("midrst_stat_grants", stat_grants, 32'd0);
`endif

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < NR; i++) begin
                req_tag[i*TW +: TW]  = 6'($urandom);
                req_data[i*DW +: DW] = $urandom;
            end
            step(8'($urandom), ($urandom_range(3) == 0), 1'b1);
        end
        step(8'h00, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
